// File: rtl/spike_rate_decoder_pkg.sv
// Shared constants, FSM state type and lane helper for the spike-rate decoder.
//   NUM_WORDS  beats per encoder frame (24x24 pixels / 4 lanes)
//   LANES      spikes per beat = pixels per count-BRAM word
//   CNT_W      per-pixel count width; WORD_W = LANES*CNT_W
//   STEP_W     step counter width, ADDR_W count-BRAM address width
package spike_rate_decoder_pkg;

  localparam int unsigned NUM_WORDS     = 144;
  localparam int unsigned LANES         = 4;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned WORD_W        = LANES * CNT_W;
  localparam int unsigned STEP_W        = 8;
  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned DEF_NUM_STEPS = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_FRM = 3'd1,
    ST_ACC      = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Add one spike to a count, holding at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             s);
    return (s && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Count-BRAM bus between the decoder and a simple dual-port BRAM.
//   rd_addr/rd_ce   read port request; rd_q valid one cycle after rd_ce
//   wr_addr/wr_d    write port address and data
//   wr_ce/wr_we     write enable and strobe (always equal)
// master = decoder side, slave = BRAM side.
interface spike_rate_decoder_if;
  import spike_rate_decoder_pkg::*;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ce;
  logic [WORD_W-1:0] rd_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_d;
  logic              wr_ce;
  logic              wr_we;

  modport master (
    output rd_addr, rd_ce, wr_addr, wr_d, wr_ce, wr_we,
    input  rd_q
  );

  modport slave (
    input  rd_addr, rd_ce, wr_addr, wr_d, wr_ce, wr_we,
    output rd_q
  );

endinterface

// File: rtl/spike_rate_decoder_sat_lane_add.sv
// LANES-wide saturating adder: each CNT_W lane of i_q plus its spike bit.
//   i_q      old count word read from the count BRAM
//   i_spike  one spike bit per lane
//   o_sum    updated count word, each lane clamped at 2^CNT_W-1
module sat_lane_add
  import spike_rate_decoder_pkg::*;
(
  input  logic [WORD_W-1:0] i_q,
  input  logic [LANES-1:0]  i_spike,
  output logic [WORD_W-1:0] o_sum
);

  always_comb begin
    o_sum = '0;
    for (int unsigned n = 0; n < LANES; n++) begin
      o_sum[n*CNT_W +: CNT_W] = sat_inc(i_q[n*CNT_W +: CNT_W], i_spike[n]);
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: accumulates per-pixel spike counts over NUM_STEPS
// encoder frames into an external count BRAM (read-modify-write pipeline).
//   clk, rst   clock, synchronous active-high reset
//   i_start    start a run (honoured only when idle; clears o_err/o_step)
//   i_w_run    frame-start pulse; first beat may follow on the next cycle
//   i_valid    spike beat valid, i_spike LANES spike bits of that beat
//   bram       count-BRAM read/write ports (master side)
//   o_busy     run in progress, o_step frames completed in this run
//   o_done     one-cycle pulse after the last count word is written
//   o_err      sticky framing error (frame restarted mid-frame)
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int unsigned NUM_STEPS = DEF_NUM_STEPS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_w_run,
  input  logic                 i_valid,
  input  logic [LANES-1:0]     i_spike,
  spike_rate_decoder_if.master bram,
  output logic                 o_busy,
  output logic [STEP_W-1:0]    o_step,
  output logic                 o_done,
  output logic                 o_err
);

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_WORDS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_beat;
  logic [STEP_W-1:0] r_step;
  logic              r_err;
  logic              r_drain;

  logic w_acc;
  logic w_restart;
  logic w_last;
  logic w_rd_ce;

  // Pipeline: stage 1 waits for read data, stage 2 drives the write port.
  logic              r_s1_vld;
  logic              r_s1_rd;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [LANES-1:0]  r_s1_spike;
  logic              r_s2_vld;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [WORD_W-1:0] r_s2_data;

  logic [WORD_W-1:0] w_old;
  logic [WORD_W-1:0] w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_restart   = 1'b0;
    w_last      = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    o_done      = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_WAIT_FRM;
      end
      ST_WAIT_FRM: begin
        if (i_w_run) w_state_nxt = ST_ACC;
      end
      ST_ACC: begin
        // A frame-start pulse wins over a beat in the same cycle: the
        // restarted frame's first beat follows on the next cycle.
        if (i_w_run) begin
          w_restart = 1'b1;
        end else if (i_valid) begin
          w_acc = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_last      = 1'b1;
            w_state_nxt = (r_step < LAST_STEP) ? ST_WAIT_FRM : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (r_drain) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat  <= '0;
      r_step  <= '0;
      r_err   <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_drain <= (r_state == ST_DRAIN) && !r_drain;
      if ((r_state == ST_IDLE) && i_start) begin
        r_beat <= '0;
        r_step <= '0;
        r_err  <= 1'b0;
      end
      if (w_restart) begin
        if (r_beat != '0) r_err <= 1'b1;
        r_beat <= '0;
      end else if (w_acc) begin
        if (w_last) begin
          r_beat <= '0;
          r_step <= r_step + STEP_W'(1);
        end else begin
          r_beat <= r_beat + ADDR_W'(1);
        end
      end
    end
  end

  // First frame of a run overwrites stale BRAM contents: no read, old = 0.
  assign w_rd_ce = w_acc && (r_step != '0);
  assign w_old   = r_s1_rd ? bram.rd_q : '0;

  sat_lane_add u_sat (
    .i_q     (w_old),
    .i_spike (r_s1_spike),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_rd    <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_spike <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_data  <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_s1_rd  <= w_rd_ce;
      if (w_acc) begin
        r_s1_addr  <= r_beat;
        r_s1_spike <= i_spike;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_addr <= r_s1_addr;
        r_s2_data <= w_sum;
      end
    end
  end

  assign bram.rd_addr = r_beat;
  assign bram.rd_ce   = w_rd_ce;
  assign bram.wr_addr = r_s2_addr;
  assign bram.wr_d    = r_s2_data;
  assign bram.wr_ce   = r_s2_vld;
  assign bram.wr_we   = r_s2_vld;

  assign o_step = r_step;
  assign o_err  = r_err;

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;
  import spike_rate_decoder_pkg::*;

  localparam int NSTEPS = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic              i_w_run = 1'b0;
  logic              i_valid = 1'b0;
  logic [LANES-1:0]  i_spike = '0;
  logic              o_busy;
  logic [STEP_W-1:0] o_step;
  logic              o_done;
  logic              o_err;

  spike_rate_decoder_if bram();

  spike_rate_decoder #(.NUM_STEPS(NSTEPS)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_w_run (i_w_run),
    .i_valid (i_valid),
    .i_spike (i_spike),
    .bram    (bram),
    .o_busy  (o_busy),
    .o_step  (o_step),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  // Count BRAM: registered read, write-first ordering irrelevant (no collisions).
  // mem_cmd: 1 = fill with random junk, 2 = preset every lane to 0xFE.
  logic [WORD_W-1:0] mem [256];
  logic [1:0]        mem_cmd = 2'd0;
  always @(posedge clk) begin
    if (mem_cmd == 2'd1) begin
      for (int a = 0; a < 256; a++) mem[a] <= $urandom;
    end else if (mem_cmd == 2'd2) begin
      for (int a = 0; a < 256; a++) mem[a] <= 32'hFEFE_FEFE;
    end else if (bram.wr_ce && bram.wr_we) begin
      mem[bram.wr_addr] <= bram.wr_d;
    end
    if (bram.rd_ce) bram.rd_q <= mem[bram.rd_addr];
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  // Reference: per-pixel counts as plain integers.
  int  ref_cnt [NUM_WORDS][LANES];
  int  model_step;
  bit  model_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && bram.wr_ce) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL wr_unexpected: write addr %0d data 0x%0h with no pending beat",
                   bram.wr_addr, bram.wr_d);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bram.wr_addr, e.addr);
          check("wr_data", bram.wr_d, e.data);
          check("wr_we", bram.wr_we, 1);
        end
      end
    end
  endtask

  function automatic logic [LANES-1:0] spike_for(input int mode);
    logic [LANES-1:0] s;
    case (mode)
      1:       s = '1;
      2:       s = LANES'(1);
      default: s = LANES'($urandom);
    endcase
    return s;
  endfunction

  task automatic send_beat(input int k, input logic [LANES-1:0] sp);
    logic [WORD_W-1:0] w;
    int old, nv;
    w = '0;
    for (int n = 0; n < LANES; n++) begin
      old = (model_step == 0) ? 0 : ref_cnt[k][n];
      nv  = old + int'(sp[n]);
      if (nv > CMAX) nv = CMAX;
      ref_cnt[k][n] = nv;
      w[n*CNT_W +: CNT_W] = CNT_W'(nv);
    end
    exp_q.push_back('{addr: ADDR_W'(k), data: w});
    i_valid = 1'b1;
    i_spike = sp;
    @(negedge clk);
    check("rd_addr", bram.rd_addr, k);
    check("rd_ce", bram.rd_ce, (model_step != 0));
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // One frame: an ignored junk beat, frame start, beats with optional gaps,
  // optional restart at beat restart_at, optional early exit at stop_at.
  task automatic do_frame(input int mode, input bit gap, input int restart_at, input int stop_at);
    int k;
    bit restarted;
    i_valid = 1'b1; i_spike = LANES'($urandom);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_w_run = 1'b1;
    @(posedge clk); #1;
    i_w_run = 1'b0;
    k = 0;
    restarted = 1'b0;
    while (k < NUM_WORDS) begin
      if (gap) begin
        i_spike = LANES'($urandom);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (k == stop_at) return;
      if (!restarted && k == restart_at) begin
        restarted = 1'b1;
        model_err = model_err | (k != 0);
        i_w_run = 1'b1;
        @(posedge clk); #1;
        i_w_run = 1'b0;
        check("err_after_restart", o_err, model_err);
        k = 0;
        continue;
      end
      send_beat(k, spike_for(mode));
      k++;
    end
    model_step++;
    check("step_inc", o_step, model_step);
  endtask

  task automatic do_run(input int mode, input bit gap, input int rs_step, input int rs_beat,
                        input bit preset);
    int cyc;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    model_step = 0;
    model_err  = 1'b0;
    check("start_err_clr", o_err, 0);
    check("start_step", o_step, 0);
    check("start_busy", o_busy, 1);
    for (int s = 0; s < NSTEPS; s++) begin
      if (preset && s == 1) begin
        repeat (3) @(posedge clk);
        #1 mem_cmd = 2'd2;
        @(posedge clk); #1;
        mem_cmd = 2'd0;
        for (int a = 0; a < NUM_WORDS; a++)
          for (int n = 0; n < LANES; n++) ref_cnt[a][n] = 'hFE;
      end
      if (s == 2) begin
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("start_ignored_step", o_step, model_step);
        check("start_ignored_err", o_err, model_err);
      end
      do_frame(mode, gap, (s == rs_step) ? rs_beat : -1, -1);
    end
    cyc = 0;
    while (!o_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", o_done, 1);
    check("done_latency", cyc, 3);
    check("done_step", o_step, NSTEPS);
    check("done_err", o_err, model_err);
    check("done_pending", exp_q.size(), 0);
    @(posedge clk); #1;
    check("idle_after_done", {o_busy, o_done}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    mem_cmd = 2'd1;
    repeat (3) @(posedge clk);
    #1 mem_cmd = 2'd0;
    check("rst_ctrl", {o_busy, o_done, o_err, o_step}, 0);
    check("rst_bus", {bram.rd_ce, bram.wr_ce, bram.wr_we, bram.rd_addr, bram.wr_addr}, 0);
    check("rst_wr_d", bram.wr_d, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // random spikes, back-to-back, harmless restart at beat 0 of the first frame
    do_run(0, 1'b0, 0, 0, 1'b0);
    // all ones with valid gaps, counts preset to 0xFE after frame 0 -> saturate at 0xFF
    do_run(1, 1'b1, -1, -1, 1'b1);
    // lane 0 only, mid-frame restart at beat 50 of frame 1 -> sticky error
    do_run(2, 1'b1, 1, 50, 1'b0);

    // reset in the middle of frame 1; in-flight writes are dropped
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    model_step = 0;
    model_err  = 1'b0;
    check("start_err_clr", o_err, 0);
    do_frame(0, 1'b0, -1, -1);
    do_frame(0, 1'b0, -1, 70);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("midrst_ctrl", {o_busy, o_done, o_err, o_step}, 0);
    check("midrst_bus", {bram.rd_ce, bram.wr_ce, bram.wr_we, bram.rd_addr, bram.wr_addr}, 0);
    check("midrst_wr_d", bram.wr_d, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // fresh run after the reset
    do_run(0, 1'b1, -1, -1, 1'b0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
